// File: rtl/dac_share_pkg.sv
// rtl/dac_share_pkg.sv - shared state encoding and timing constants for the DAC share scheduler
package dac_share_pkg;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_START     = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd2;
   localparam logic [1:0] ST_GAP       = 2'd3;

   // serializer cycles from start pulse to done pulse for one 16-bit frame
   localparam int DAC_FRAME_CYCLES       = 17;
   localparam int DEFAULT_GAP_CYCLES     = 2;
   localparam int DEFAULT_TIMEOUT_CYCLES = 64;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set request at or above ptr, wrapping
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid
);

   logic [IDX_W:0] cand;

   always_comb begin
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_REQ))
            cand = cand - (IDX_W+1)'(NUM_REQ);
         if (!grant_valid && req[cand[IDX_W-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/dac_share_scheduler.sv
// rtl/dac_share_scheduler.sv - round-robin sharing of one DAC serializer with frame gap and done watchdog
module dac_share_scheduler
   import dac_share_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_W         = 8,
   parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         ack,
   output logic                       dac_start,
   output logic [DATA_W-1:0]          dac_din,
   input  logic                       dac_done,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       timeout_err
);

   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

   logic [1:0]        state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  arb_idx;
   logic              arb_valid;
   logic [WAIT_W-1:0] wait_cnt;
   logic [GAP_W-1:0]  gap_cnt;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req         (req),
      .ptr         (rr_ptr),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   assign dac_start = (state == ST_START);
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         dac_din     <= '0;
         ack         <= '0;
         timeout_err <= 1'b0;
         wait_cnt    <= '0;
         gap_cnt     <= '0;
      end else begin
         ack <= '0;
         case (state)
            ST_IDLE: begin
               if (arb_valid) begin
                  grant_id <= arb_idx;
                  dac_din  <= req_data[arb_idx*DATA_W +: DATA_W];
                  state    <= ST_START;
               end
            end
            ST_START: begin
               wait_cnt <= '0;
               state    <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               wait_cnt <= wait_cnt + WAIT_W'(1);
               // a done arriving on the last allowed cycle still counts as a clean frame
               if (dac_done || wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                  if (!dac_done)
                     timeout_err <= 1'b1;
                  ack[grant_id] <= 1'b1;
                  gap_cnt       <= '0;
                  state         <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                  rr_ptr <= IDX_W'(wrap_inc(int'(grant_id), NUM_REQ));
                  state  <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dac_share_scheduler.sv
// tb/tb_dac_share_scheduler.sv - scoreboard bench for dac_share_scheduler
module tb_dac_share_scheduler;
   import dac_share_pkg::*;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int GAP = DEFAULT_GAP_CYCLES;
   localparam int TMO = DEFAULT_TIMEOUT_CYCLES;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    ack;
   logic            dac_start;
   logic [DW-1:0]   dac_din;
   logic            dac_done = 1'b0;
   logic            busy;
   logic [1:0]      grant_id;
   logic            timeout_err;

   dac_share_scheduler #(
      .NUM_REQ        (N),
      .DATA_W         (DW),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .ack         (ack),
      .dac_start   (dac_start),
      .dac_din     (dac_din),
      .dac_done    (dac_done),
      .busy        (busy),
      .grant_id    (grant_id),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int id;
      int val;
   } exp_t;

   exp_t exp_start[$];
   exp_t exp_ack[$];

   int n_cmp = 0;
   int n_bad = 0;

   // reference model and stimulus knobs
   int            ptr_m = 0;
   int            free_at = 0;
   bit            to_m = 1'b0;
   int            frame_delay = DAC_FRAME_CYCLES;
   int            next_delay = DAC_FRAME_CYCLES;
   bit            delay_rand = 1'b0;
   bit            spur_en = 1'b0;
   int            raise_pct = 0;
   int            done_at = -1;
   int            wait_lo = 0;
   int            wait_hi = -1;
   logic [N-1:0]  auto_mask = '0;
   logic [DW-1:0] auto_data [N];
   logic [N-1:0]  stage = '0;
   logic [DW-1:0] stage_d [N];

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic stage_req(input int i, input logic [DW-1:0] d);
      stage[i]   = 1'b1;
      stage_d[i] = d;
   endtask

   task automatic do_cycle();
      int   c;
      int   g;
      int   a;
      exp_t t;
      c = cyc;
      for (int i = 0; i < N; i++) begin
         if (!req[i]) begin
            if (stage[i]) begin
               req[i] = 1'b1;
               req_data[i*DW +: DW] = stage_d[i];
               stage[i] = 1'b0;
            end else if (auto_mask[i]) begin
               req[i] = 1'b1;
               req_data[i*DW +: DW] = auto_data[i];
            end else if (raise_pct > 0 && int'($urandom_range(99, 0)) < raise_pct) begin
               req[i] = 1'b1;
               req_data[i*DW +: DW] = DW'($urandom);
            end
         end
         if (ack[i])
            req[i] = 1'b0;
      end
      // grant decision: the scheduler is idle from free_at onward
      if (c >= free_at && req != '0) begin
         g = -1;
         for (int k = 0; k < N; k++) begin
            int i2 = (ptr_m + k) % N;
            if (g < 0 && req[i2])
               g = i2;
         end
         frame_delay = delay_rand ? int'($urandom_range(TMO, 1)) : next_delay;
         t.cyc = c + 1;
         t.id  = g;
         t.val = int'(req_data[g*DW +: DW]);
         exp_start.push_back(t);
         if (frame_delay != 0 && frame_delay <= TMO) begin
            a = c + 1 + frame_delay + 1;
         end else begin
            a = c + 1 + TMO + 1;
            to_m = 1'b1;
         end
         t.cyc = a;
         t.val = int'(to_m);
         exp_ack.push_back(t);
         free_at = a + GAP;
         ptr_m   = (g + 1) % N;
         wait_lo = c + 2;
         wait_hi = a - 1;
      end
      // serializer model reacting to the DUT start pulse
      if (dac_start)
         done_at = (frame_delay == 0) ? -1 : c + frame_delay;
      dac_done = (c == done_at) ||
                 (spur_en && (c < wait_lo || c > wait_hi) && $urandom_range(3, 0) == 0);
   endtask

   task automatic tick();
      @(negedge clk);
      do_cycle();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_start.size() + exp_ack.size() > 0 || cyc < free_at || req != '0 || stage != '0)
             && n < budget) begin
         tick();
         n++;
      end
      check("drain_pending", exp_start.size() + exp_ack.size(), 0);
      check("drain_req_left", req, 0);
   endtask

   task automatic reset_checks();
      check("rst_ack", ack, 0);
      check("rst_dac_start", dac_start, 0);
      check("rst_dac_din", dac_din, 0);
      check("rst_busy", busy, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_timeout_err", timeout_err, 0);
   endtask

   task automatic pulse_reset(input logic [N-1:0] keep);
      #2 rst = 1'b1;
      #1;
      reset_checks();
      exp_start.delete();
      exp_ack.delete();
      ptr_m    = 0;
      to_m     = 1'b0;
      done_at  = -1;
      wait_lo  = 0;
      wait_hi  = -1;
      dac_done = 1'b0;
      req      = req & keep;
      @(negedge clk);
      @(negedge clk);
      rst     = 1'b0;
      free_at = cyc;
      do_cycle();
   endtask

   // scoreboard monitor
   exp_t e;
   int   last_din = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (exp_start.size() > 0 && exp_start[0].cyc < cyc) begin
            e = exp_start.pop_front();
            check("start_by_cycle", cyc, e.cyc);
         end
         if (exp_ack.size() > 0 && exp_ack[0].cyc < cyc) begin
            e = exp_ack.pop_front();
            check("ack_by_cycle", cyc, e.cyc);
         end
         if (dac_start) begin
            if (exp_start.size() == 0) begin
               check("start_unexpected", dac_start, 0);
            end else begin
               e = exp_start.pop_front();
               check("start_cycle", cyc, e.cyc);
               check("grant_id", grant_id, e.id);
               check("dac_din", dac_din, e.val);
               check("busy_in_start", busy, 1);
               check("ack_in_start", ack, 0);
               last_din = e.val;
            end
         end
         if (ack != '0) begin
            if (exp_ack.size() == 0) begin
               check("ack_unexpected", ack, 0);
            end else begin
               e = exp_ack.pop_front();
               check("ack_cycle", cyc, e.cyc);
               check("ack_vec", ack, 1 << e.id);
               check("ack_timeout_err", timeout_err, e.val);
               check("ack_busy", busy, 1);
               check("dac_din_hold", dac_din, last_din);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         auto_data[i] = DW'((i + 1) * 16);
         stage_d[i]   = '0;
      end
      repeat (3) @(negedge clk);
      reset_checks();
      rst     = 1'b0;
      free_at = cyc;
      do_cycle();

      // all four requesting continuously from a fresh pointer
      auto_mask = '1;
      repeat (5 * (19 + GAP)) tick();
      auto_mask = '0;
      drain(400);

      // single request after reset
      pulse_reset('0);
      stage_req(1, 8'hA5);
      drain(100);

      // fairness: req0 always pending, req2 raised mid-frame
      auto_mask = 4'b0001;
      repeat (9) tick();
      stage_req(2, 8'h5A);
      repeat (60) tick();
      auto_mask = '0;
      drain(200);

      // done on the last allowed wait cycle and one before it
      next_delay = TMO;
      stage_req(3, 8'hC3);
      drain(200);
      next_delay = TMO - 1;
      stage_req(0, 8'h3C);
      drain(200);

      // randomized traffic, random done latency, spurious done outside the wait window
      delay_rand = 1'b1;
      spur_en    = 1'b1;
      raise_pct  = 8;
      repeat (1500) tick();
      raise_pct = 0;
      drain(800);
      delay_rand = 1'b0;
      spur_en    = 1'b0;

      // watchdog: no done at all, then done one cycle too late, then a normal frame
      next_delay = 0;
      stage_req(2, 8'h77);
      drain(200);
      next_delay = TMO + 1;
      stage_req(1, 8'h88);
      drain(200);
      next_delay = DAC_FRAME_CYCLES;
      stage_req(3, 8'h99);
      drain(100);
      check("timeout_sticky", timeout_err, 1);

      // reset during WAIT_DONE with req3 pending behind the aborted frame
      stage_req(0, 8'h11);
      repeat (6) tick();
      stage_req(3, 8'h33);
      repeat (2) tick();
      check("busy_before_reset", busy, 1);
      pulse_reset(4'b1000);
      drain(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dac_share_scheduler.md
Name: dac_share_scheduler

Overview:
- Shares one DAC5311 SPI serializer (start pulse in, done pulse out, 8-bit code) between NUM_REQ independent requesters, e.g. the brightness and audio-level tasks of the LED screen.
- Round-robin arbitration, one 16-bit SPI frame per grant.
- Enforces a minimum SYNC-high gap between frames.
- Watchdogs a missing done pulse so a stuck serializer cannot hang the requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, DAC code width; must match the serializer din.
- GAP_CYCLES, 2, idle cycles inserted after each frame before the next start (>=1).
- TIMEOUT_CYCLES, 64, maximum WAIT_DONE cycles before abort (>=20).

Ports:
- clk  in  1  system clock; also the serializer clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-requester request level.
- req_data  in  NUM_REQ*DATA_W  packed codes; requester i uses bits [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- dac_start  out  1  one-cycle start pulse to the serializer.
- dac_din  out  DATA_W  code to the serializer; held stable from dac_start until the next grant.
- dac_done  in  1  serializer done pulse.
- busy  out  1  high in every state except IDLE.
- grant_id  out  clog2(NUM_REQ)  index of the current or last grant.
- timeout_err  out  1  sticky; set on a watchdog abort, cleared only by rst.

Behaviour:
- Reset values: ack=0, dac_start=0, dac_din=0, busy=0, grant_id=0, timeout_err=0. RR pointer=0. State=IDLE. All counters=0.
- Reset mid-frame aborts immediately; no ack is issued for the aborted frame.
- The serializer uses an active-low reset; the top level inverts rst for it.

FSM states: IDLE, START, WAIT_DONE, GAP.
- IDLE, any req bit high at edge t:
  - pick the first set bit scanning from the RR pointer upward, wrapping;
  - latch grant_id and dac_din from that requester's slice;
  - go to START.
  - So dac_start is high in cycle t+1.
- START: dac_start=1 for exactly one cycle, then WAIT_DONE. The wait counter is cleared.
- WAIT_DONE:
  - wait counter increments each cycle.
  - dac_done=1 -> ack[grant_id]=1 next cycle; go to GAP.
  - Counter reaches TIMEOUT_CYCLES without done -> set timeout_err, ack[grant_id]=1 next cycle, go to GAP.
  - If done and timeout coincide, done wins and timeout_err is not set.
- GAP:
  - count GAP_CYCLES cycles, then go to IDLE;
  - RR pointer = grant_id+1, wrapping from NUM_REQ-1 to 0.
- Nominal latency: req seen -> dac_start 1 cycle; dac_start -> dac_done 17 cycles; ack 1 cycle after dac_done. Requester-to-requester frame spacing = 19 + GAP_CYCLES cycles.
- Requester rules:
  - hold req and req_data stable until ack;
  - drop req in the ack cycle or the cycle after.
  - GAP_CYCLES>=1 guarantees no double service.
- Changes on req or req_data outside IDLE are ignored; data is latched only at grant.
- dac_done outside WAIT_DONE is ignored.
- A requester whose req falls before grant is simply not selected. No error is raised.
- Exactly one ack bit is high at a time. ack is never high in IDLE or START.

Decomposition:
- Shared package dac_share_pkg holds:
  - the state encoding constants (IDLE=0, START=1, WAIT_DONE=2, GAP=3);
  - DAC_FRAME_CYCLES=17;
  - the default GAP and TIMEOUT values.
- One sub-module rr_arbiter (combinational priority pick from req and pointer, outputs index and valid). The pointer register stays in the top.

Test Plan:
- Single request: req=4'b0010, data1=8'hA5 -> dac_start at t+1, dac_din=8'hA5, grant_id=1; serializer model returns done 17 cycles later; ack=4'b0010 one cycle after done.
- All four requesting continuously with distinct codes 8'h10/8'h20/8'h30/8'h40 -> grant order 0,1,2,3,0. Each dac_start is 21 cycles apart (GAP=2). No ack overlap.
- Fairness: req0 held permanently, req2 raised mid-frame of req0 -> next grant is 2, not 0.
- Timeout: serializer model never asserts done -> after 64 WAIT_DONE cycles timeout_err=1 and ack pulses. The next request is still served; timeout_err stays 1.
- Done coinciding with the timeout cycle (TIMEOUT_CYCLES=20, done at wait count 20) -> ack pulses, timeout_err stays 0.
- rst asserted during WAIT_DONE -> all outputs 0 asynchronously, no ack. After release, a pending req3 is served first via the pointer=0 scan (index 3 is the only request).
